plru_repl_ctrl: RTL and testbench
=================================

# plru_repl_ctrl

Per-set replacement-state controller for the set-associative caches. It holds one tree-PLRU node vector per set and serves one lookup or allocation per cycle. Each request updates that set's tree. Misses get a one-hot victim way, with invalid ways preferred over the PLRU choice. It sits between the cache tag-compare stage and the refill/allocation logic, and it owns clearing of the replacement state after reset and on flush.

## Interface
- NUM_SET, 64, number of sets; power of two, ≥2
- NUM_WAY, 4, associativity; power of two, ≥2; tree has NUM_WAY-1 nodes
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  start a clear sweep of all replacement state (sampled only in IDLE)
- busy_o  out  1  high while INIT or FLUSH sweep in progress
- req_valid_i  in  1  request present
- req_ready_o  out  1  request accepted when req_valid_i & req_ready_o at a rising edge
- req_set_i  in  $clog2(NUM_SET)  set index
- req_hit_i  in  1  1 = hit (update only), 0 = miss (select victim and update)
- req_hit_vec_i  in  NUM_WAY  one-hot hit way; must be one-hot when req_hit_i=1
- req_way_valid_i  in  NUM_WAY  valid bits of the set's ways (used on miss)
- rsp_valid_o  out  1  response valid, one cycle per accepted request, no backpressure
- rsp_way_o  out  NUM_WAY  one-hot way: the hit way on a hit, the chosen victim on a miss
- rsp_hit_o  out  1  echo of req_hit_i
- rsp_set_o  out  $clog2(NUM_SET)  echo of req_set_i

## Operation
- Storage is NUM_SET × (NUM_WAY-1) bits, implemented without reset (SRAM-mappable). It is cleared only by the sweep.
- Node encoding: nodes are numbered level by level. The index is (2^lvl - 1) + (way >> (L - lvl)), with L = log2(NUM_WAY).
  - Access of a way sets each node on its path to the inverse of that way's bit at that level (the node points away from the way).
  - The PLRU victim is the way whose path bits all equal the stored node bits. An all-zero tree therefore selects way 0.
- Hit: the way is req_hit_vec_i and the tree is updated as an access to it.
- Miss: the way is the lowest-index way with req_way_valid_i=0. If all ways are valid, it is the PLRU victim. The tree is updated as an access to the chosen way, because allocation counts as a use.
- FSM states:
  - INIT: entered on reset. Sweep counter starts at 0 and one set is zeroed per cycle. After set NUM_SET-1 is written → IDLE.
  - IDLE: requests are served. flush_i=1 → FLUSH.
  - FLUSH: same sweep as INIT, then → IDLE. flush_i is ignored in INIT and FLUSH (no restart).
- req_ready_o = (state==IDLE) & ~flush_i. Flush has priority over a same-cycle request; that request is not accepted.
- Stage S1 is a single register holding the accepted request.
  - In the S1 cycle the array is read combinationally, and the way and new tree are computed.
  - The response is driven from S1, and the write happens at the end of the S1 cycle.
  - Sweep writes and S1 writes never coincide, because an S1 write always precedes the first sweep write.
- If req_hit_i=1 and req_hit_vec_i is not one-hot, the behaviour is undefined. Verification asserts against it.

## Timing
- Reset values:
  - busy_o=1, req_ready_o=0, rsp_valid_o=0, rsp_way_o=0, rsp_hit_o=0, rsp_set_o=0
  - state=INIT, sweep counter=0, S1 valid=0
- INIT after rst_ni deassert:
  - Sweep writes occur in cycles 0..NUM_SET-1.
  - busy_o falls and req_ready_o rises in cycle NUM_SET (64 with defaults).
- Request latency: accepted at edge E → rsp_valid_o=1 in the cycle after E, for exactly one cycle.
  - The tree is written at edge E+1.
  - Throughput is one request per cycle.
- Back-to-back requests to the same set see the previous update, because the write occurs before the next S1 read. No forwarding is needed.
- flush_i asserted in cycle C while in IDLE:
  - Any in-flight S1 completes normally (response and write at edge C+1).
  - FLUSH is active from C+1; sweep writes run for NUM_SET cycles; IDLE returns NUM_SET cycles later.
- Asynchronous reset in any state:
  - All outputs return to their reset values immediately, and any in-flight response is dropped.
  - The INIT sweep restarts from set 0.

## Test plan
- Reset release with defaults → busy_o=1 for 64 cycles. Then a miss on set 5 with req_way_valid_i=1111 → rsp_way_o=0001 one cycle after acceptance.
- After INIT, set 3: hit way0, then hit way2, then miss with all valid → rsp_way_o=0010 (tree n0=0, n1=1, n2=1).
- Miss on set 9 with req_way_valid_i=1011, regardless of tree contents → rsp_way_o=0100.
- Back-to-back misses on set 7 on consecutive cycles, all valid, from a cleared tree → responses 0001 then 0100 on consecutive cycles.
- After traffic on set 7, assert flush_i together with req_valid_i:
  - The request is not accepted, and busy_o is high for 64 cycles.
  - A subsequent miss on set 7, all valid → 0001.
- Assert rst_ni=0 mid-FLUSH with an S1 response pending:
  - rsp_valid_o=0 immediately.
  - On release, busy_o is high for 64 cycles, then a miss on any set → 0001.

Source files
------------

// File: rtl/plru_repl_ctrl_if.sv
// Request/response bundle between tag-compare, the PLRU replacement controller
// and the refill/allocation logic.
interface plru_repl_ctrl_if #(
   parameter int NUM_SET = 64,
   parameter int NUM_WAY = 4
);
   localparam int SET_W = $clog2(NUM_SET);

   logic               flush_i;
   logic               busy_o;
   logic               req_valid_i;
   logic               req_ready_o;
   logic [SET_W-1:0]   req_set_i;
   logic               req_hit_i;
   logic [NUM_WAY-1:0] req_hit_vec_i;
   logic [NUM_WAY-1:0] req_way_valid_i;
   logic               rsp_valid_o;
   logic [NUM_WAY-1:0] rsp_way_o;
   logic               rsp_hit_o;
   logic [SET_W-1:0]   rsp_set_o;

   modport master (
      output flush_i, req_valid_i, req_set_i, req_hit_i, req_hit_vec_i, req_way_valid_i,
      input  busy_o, req_ready_o, rsp_valid_o, rsp_way_o, rsp_hit_o, rsp_set_o
   );

   modport slave (
      input  flush_i, req_valid_i, req_set_i, req_hit_i, req_hit_vec_i, req_way_valid_i,
      output busy_o, req_ready_o, rsp_valid_o, rsp_way_o, rsp_hit_o, rsp_set_o
   );
endinterface

// File: rtl/plru_repl_ctrl.sv
// Per-set tree-PLRU replacement controller: one lookup/allocation per cycle,
// invalid ways preferred on a miss, swept clear after reset and on flush.
//
// state    | meaning
// ST_INIT  | post-reset sweep, one set zeroed per cycle
// ST_IDLE  | requests served, flush_i starts a sweep
// ST_FLUSH | flush sweep, identical to INIT, then back to IDLE
module plru_repl_ctrl #(
   parameter int NUM_SET = 64,
   parameter int NUM_WAY = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   plru_repl_ctrl_if.slave bus
);
   localparam int SET_W = $clog2(NUM_SET);
   localparam int LVL   = $clog2(NUM_WAY);
   localparam int NODE  = NUM_WAY - 1;

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_FLUSH} state_t;

   state_t             state;
   logic [SET_W-1:0]   sweep_cnt;
   logic               sweep_last;
   logic               busy_q;
   logic               idle_q;
   logic               accept;

   logic               s1_valid;
   logic               s1_hit;
   logic [SET_W-1:0]   s1_set;
   logic [NUM_WAY-1:0] s1_hit_vec;
   logic [NUM_WAY-1:0] s1_way_valid;

   logic [NODE-1:0]    tree_mem [NUM_SET];
   logic [NODE-1:0]    tree_rd;
   logic [NODE-1:0]    tree_new;
   logic [NUM_WAY-1:0] plru_oh;
   logic [NUM_WAY-1:0] free_vec;
   logic [NUM_WAY-1:0] free_oh;
   logic [NUM_WAY-1:0] way_oh;

   assign sweep_last      = (sweep_cnt == SET_W'(NUM_SET - 1));
   assign bus.req_ready_o = idle_q & ~bus.flush_i;
   assign accept          = bus.req_valid_i & bus.req_ready_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= ST_INIT;
         sweep_cnt <= '0;
         busy_q    <= 1'b1;
         idle_q    <= 1'b0;
      end else begin
         case (state)
            ST_INIT, ST_FLUSH: begin
               if (sweep_last) begin
                  state     <= ST_IDLE;
                  sweep_cnt <= '0;
                  busy_q    <= 1'b0;
                  idle_q    <= 1'b1;
               end else begin
                  sweep_cnt <= sweep_cnt + 1'b1;
               end
            end
            ST_IDLE: begin
               if (bus.flush_i) begin
                  state  <= ST_FLUSH;
                  busy_q <= 1'b1;
                  idle_q <= 1'b0;
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid     <= 1'b0;
         s1_hit       <= 1'b0;
         s1_set       <= '0;
         s1_hit_vec   <= '0;
         s1_way_valid <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_hit       <= bus.req_hit_i;
            s1_set       <= bus.req_set_i;
            s1_hit_vec   <= bus.req_hit_vec_i;
            s1_way_valid <= bus.req_way_valid_i;
         end
      end
   end

   // A way is the PLRU victim when every node on its path already points at it.
   always_comb begin
      tree_rd = tree_mem[s1_set];
      plru_oh = '0;
      for (int w = 0; w < NUM_WAY; w++) begin
         plru_oh[w] = 1'b1;
         for (int l = 0; l < LVL; l++) begin
            if (tree_rd[(1 << l) - 1 + (w >> (LVL - l))] != (((w >> (LVL - 1 - l)) & 1) == 1))
               plru_oh[w] = 1'b0;
         end
      end

      free_vec = ~s1_way_valid;
      free_oh  = free_vec & (~free_vec + 1'b1);

      if (s1_hit)
         way_oh = s1_hit_vec;
      else if (|free_vec)
         way_oh = free_oh;
      else
         way_oh = plru_oh;

      tree_new = tree_rd;
      for (int w = 0; w < NUM_WAY; w++) begin
         if (way_oh[w]) begin
            for (int l = 0; l < LVL; l++)
               tree_new[(1 << l) - 1 + (w >> (LVL - l))] = (((w >> (LVL - 1 - l)) & 1) == 0);
         end
      end
   end

   // Unreset storage; an S1 write always lands before the first sweep write.
   always_ff @(posedge clk_i) begin
      if (s1_valid)
         tree_mem[s1_set] <= tree_new;
      else if (state != ST_IDLE)
         tree_mem[sweep_cnt] <= '0;
   end

   assign bus.busy_o      = busy_q;
   assign bus.rsp_valid_o = s1_valid;
   assign bus.rsp_way_o   = s1_valid ? way_oh : '0;
   assign bus.rsp_hit_o   = s1_hit;
   assign bus.rsp_set_o   = s1_set;
endmodule

// File: tb/tb_plru_repl_ctrl.sv
// Directed plus randomized bench for plru_repl_ctrl against a node-walking
// tree-PLRU reference model.
module tb_plru_repl_ctrl;
   localparam int NS = 64;
   localparam int NW = 4;
   localparam int LW = 2;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   bit       mtree [NS][NW-1];
   logic [NW-1:0] last_way;

   plru_repl_ctrl_if #(.NUM_SET(NS), .NUM_WAY(NW)) bus ();

   plru_repl_ctrl #(.NUM_SET(NS), .NUM_WAY(NW)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      if (bus.req_valid_i && bus.req_ready_o && bus.req_hit_i)
         assert ($onehot(bus.req_hit_vec_i))
         else $error("FAIL hit_vec_onehot observed=%b", bus.req_hit_vec_i);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_clear();
      for (int s = 0; s < NS; s++)
         for (int n = 0; n < NW - 1; n++)
            mtree[s][n] = 1'b0;
   endfunction

   // Walk root to leaf following stored bits; an access flips its path away.
   function automatic int model_req(input int set, input bit hit,
                                    input logic [NW-1:0] hv, input logic [NW-1:0] vv);
      int way = -1;
      int node;
      bit b;
      if (hit) begin
         for (int w = 0; w < NW; w++) if (hv[w]) way = w;
      end else begin
         for (int w = NW - 1; w >= 0; w--) if (!vv[w]) way = w;
         if (way < 0) begin
            way  = 0;
            node = 0;
            for (int l = 0; l < LW; l++) begin
               b    = mtree[set][node];
               way  = way * 2 + int'(b);
               node = 2 * node + 1 + int'(b);
            end
         end
      end
      node = 0;
      for (int l = 0; l < LW; l++) begin
         b = ((way >> (LW - 1 - l)) & 1) == 1;
         mtree[set][node] = !b;
         node = 2 * node + 1 + int'(b);
      end
      return way;
   endfunction

   task automatic issue(input int set, input bit hit, input logic [NW-1:0] hv,
                        input logic [NW-1:0] vv);
      bus.req_valid_i     = 1'b1;
      bus.req_set_i       = 6'(set);
      bus.req_hit_i       = hit;
      bus.req_hit_vec_i   = hv;
      bus.req_way_valid_i = vv;
      #1;
      chk("req_ready", 32'(bus.req_ready_o), 32'd1);
   endtask

   task automatic tick();
      bit acc;
      int way = 0;
      int set;
      bit hit;
      acc = bus.req_valid_i && bus.req_ready_o;
      set = int'(bus.req_set_i);
      hit = bus.req_hit_i;
      if (acc) way = model_req(set, hit, bus.req_hit_vec_i, bus.req_way_valid_i);
      @(posedge clk_i);
      #1;
      bus.req_valid_i = 1'b0;
      last_way = bus.rsp_way_o;
      if (acc) begin
         chk("rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
         chk("rsp_way", 32'(bus.rsp_way_o), 32'(1 << way));
         chk("rsp_hit", 32'(bus.rsp_hit_o), 32'(hit));
         chk("rsp_set", 32'(bus.rsp_set_o), 32'(set));
      end else begin
         chk("rsp_idle", 32'(bus.rsp_valid_o), 32'd0);
      end
   endtask

   task automatic wait_busy(input string tag);
      int n = 0;
      while (bus.busy_o === 1'b1 && n < 200) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      chk(tag, 32'(n), 32'd64);
      chk({tag, "_ready"}, 32'(bus.req_ready_o), 32'd1);
      model_clear();
   endtask

   initial begin
      bus.flush_i         = 1'b0;
      bus.req_valid_i     = 1'b0;
      bus.req_set_i       = '0;
      bus.req_hit_i       = 1'b0;
      bus.req_hit_vec_i   = '0;
      bus.req_way_valid_i = '0;
      last_way            = '0;

      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_busy", 32'(bus.busy_o), 32'd1);
      chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      chk("rst_rsp_way", 32'(bus.rsp_way_o), 32'd0);
      chk("rst_rsp_hit", 32'(bus.rsp_hit_o), 32'd0);
      chk("rst_rsp_set", 32'(bus.rsp_set_o), 32'd0);
      rst_ni = 1'b1;
      wait_busy("init_len");

      issue(5, 1'b0, 4'b0000, 4'b1111);
      tick();
      chk("plan_set5", 32'(last_way), 32'b0001);
      tick();

      issue(3, 1'b1, 4'b0001, 4'b1111);
      tick();
      issue(3, 1'b1, 4'b0100, 4'b1111);
      tick();
      issue(3, 1'b0, 4'b0000, 4'b1111);
      tick();
      chk("plan_set3", 32'(last_way), 32'b0010);

      issue(9, 1'b0, 4'b0000, 4'b1011);
      tick();
      chk("plan_set9", 32'(last_way), 32'b0100);

      issue(7, 1'b0, 4'b0000, 4'b1111);
      tick();
      chk("plan_b2b_0", 32'(last_way), 32'b0001);
      issue(7, 1'b0, 4'b0000, 4'b1111);
      tick();
      chk("plan_b2b_1", 32'(last_way), 32'b0100);

      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            tick();
         end else begin
            issue(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  4'(1 << $urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15)));
            tick();
         end
      end

      bus.flush_i         = 1'b1;
      bus.req_valid_i     = 1'b1;
      bus.req_set_i       = 6'd7;
      bus.req_hit_i       = 1'b0;
      bus.req_way_valid_i = 4'hF;
      #1;
      chk("flush_ready", 32'(bus.req_ready_o), 32'd0);
      tick();
      bus.flush_i = 1'b0;
      wait_busy("flush_len");
      issue(7, 1'b0, 4'b0000, 4'b1111);
      tick();
      chk("plan_flush_set7", 32'(last_way), 32'b0001);

      issue(12, 1'b0, 4'b0000, 4'b1111);
      tick();
      bus.flush_i = 1'b1;
      #1;
      rst_ni = 1'b0;
      #1;
      chk("arst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      chk("arst_rsp_way", 32'(bus.rsp_way_o), 32'd0);
      chk("arst_busy", 32'(bus.busy_o), 32'd1);
      bus.flush_i = 1'b0;
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      wait_busy("reinit_len");
      issue(33, 1'b0, 4'b0000, 4'b1111);
      tick();
      chk("plan_reinit", 32'(last_way), 32'b0001);

      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      repeat (20) @(posedge clk_i);
      #1;
      chk("midflush_busy", 32'(bus.busy_o), 32'd1);
      rst_ni = 1'b0;
      #1;
      chk("midflush_rst_ready", 32'(bus.req_ready_o), 32'd0);
      chk("midflush_rst_rsp", 32'(bus.rsp_valid_o), 32'd0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      wait_busy("midflush_reinit_len");
      issue(7, 1'b0, 4'b0000, 4'b1111);
      tick();
      chk("plan_midflush", 32'(last_way), 32'b0001);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
